// File: rtl/psram_pkg.sv
// PSRAM arbiter shared definitions.
// FSM encoding, size codes, default widths, wrap helper.
package psram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] SIZE_1B = 3'b000;
    localparam logic [2:0] SIZE_2B = 3'b001;
    localparam logic [2:0] SIZE_4B = 3'b010;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;

    function automatic int unsigned wrap_inc(
        input int unsigned i,
        input int unsigned n
    );
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/psram_arbiter_rr_select.sv
// Round-robin requester picker.
// Searches upward from ptr, wrapping to 0.
module rr_select
    import psram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic        found;
    int unsigned cand;

    // first requesting slot at or above ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 32'(ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
            cand = wrap_inc(cand, NUM_REQ);
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter of NUM_REQ masters onto one PSRAM controller.
// Define PSRAM_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rd_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_start,
    output logic                      mem_rd_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [2:0]                mem_size,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_done,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_oh;
    logic [NUM_REQ-1:0] cur_oh;
    logic               take;
    logic               to_hit;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req   (req),
        .ptr   (ptr),
        .grant (sel_oh),
        .idx   (sel_idx)
    );

    assign take      = (state == IDLE) && (|req);
    assign cur_oh    = NUM_REQ'(1) << cur;
    assign gnt       = (take && !rst) ? sel_oh : '0;
    assign mem_start = (state == ISSUE) && !rst;
    assign busy      = (state != IDLE);

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    assign to_hit = (state == WAIT) && !mem_done
                 && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // watchdog count of WAIT cycles and sticky error flag for RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= '0;
            else if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == ISSUE)
                err_q <= 1'b0;
            else if (to_hit)
                err_q <= 1'b1;
        end
    end

    assign rsp_done = (state == RESP && !err_q && !rst) ? cur_oh : '0;
    assign rsp_err  = (state == RESP &&  err_q && !rst) ? cur_oh : '0;
`else
    assign to_hit   = 1'b0;
    assign rsp_done = (state == RESP && !rst) ? cur_oh : '0;
    assign rsp_err  = '0;
`endif

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mem_done || to_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, pointer, latched request fields and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            mem_rd_wr <= 1'b0;
            mem_addr  <= '0;
            mem_size  <= SIZE_4B;
            mem_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                cur       <= sel_idx;
                mem_rd_wr <= req_rd_wr[sel_idx];
                mem_addr  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
                mem_size  <= req_size[sel_idx*3 +: 3];
                mem_wdata <= req_wdata[sel_idx*DATA_W +: DATA_W];
            end
            if (state == WAIT && mem_done && mem_rd_wr)
                rsp_rdata <= mem_rdata;
            if (state == RESP)
                ptr <= IDX_W'(wrap_inc(32'(cur), NUM_REQ));
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed testbench for psram_arbiter.
// Timeout case runs only when PSRAM_ARB_TIMEOUT_EN is defined.
module tb_psram_arbiter;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_rd_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*3-1:0]  req_size;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rsp_done;
    logic [N-1:0]  rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_start;
    logic          mem_rd_wr;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_size;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    psram_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rd_wr (req_rd_wr),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_done  (rsp_done),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_start (mem_start),
        .mem_rd_wr (mem_rd_wr),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic txn_rd(input int k, input logic [31:0] d);
        req = N'(1 << k);
        smp();
        chk("txn_gnt", gnt, 64'(1 << k));
        next();
        req = '0;
        smp();
        chk("txn_start", mem_start, 1);
        next();
        mem_done  = 1'b1;
        mem_rdata = d;
        next();
        mem_done  = 1'b0;
        mem_rdata = '0;
        smp();
        chk("txn_done", rsp_done, 64'(1 << k));
        chk("txn_rdata", rsp_rdata, d);
        next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        rst       = 1'b1;
        req       = '0;
        req_rd_wr = '0;
        req_addr  = '0;
        req_size  = {3{3'b010}};
        req_wdata = '0;
        mem_rdata = '0;
        mem_done  = 1'b0;

        // reset state
        next();
        next();
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_start", mem_start, 0);
        chk("rst_size", mem_size, 3'b010);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rdwr", mem_rd_wr, 0);
        next();
        rst = 1'b0;

        // single read, mem_done 5 cycles after mem_start
        req_addr[0 +: AW] = 24'h000100;
        req_rd_wr[0]      = 1'b1;
        req               = 3'b001;
        smp();
        chk("rd_gnt", gnt, 3'b001);
        next();
        req = '0;
        smp();
        chk("rd_start", mem_start, 1);
        chk("rd_addr", mem_addr, 24'h000100);
        chk("rd_dir", mem_rd_wr, 1);
        repeat (4) begin
            next();
            smp();
            chk("rd_wait", {busy, mem_start, rsp_done}, 5'b10000);
        end
        next();
        mem_done  = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        smp();
        chk("rd_early", rsp_done, 0);
        next();
        mem_done  = 1'b0;
        mem_rdata = '0;
        smp();
        chk("rd_done", rsp_done, 3'b001);
        chk("rd_data", rsp_rdata, 32'hDEADBEEF);
        next();
        smp();
        chk("rd_idle", {busy, rsp_done}, 0);

        // stray mem_done while idle
        next();
        mem_done  = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        smp();
        chk("stray_now", {busy, gnt, rsp_done, mem_start}, 0);
        next();
        mem_done  = 1'b0;
        mem_rdata = '0;
        smp();
        chk("stray_after", {busy, rsp_done}, 0);
        chk("stray_rdata", rsp_rdata, 32'hDEADBEEF);
        next();

        // fairness with all requesters active
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(24'h010000 * (i + 1));
            req_rd_wr[i]         = 1'b1;
        end
        req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            k = t % N;
            n = 0;
            smp();
            while (gnt == '0 && n < 8) begin
                smp();
                n++;
            end
            chk("fair_gnt", gnt, 64'(1 << k));
            chk("fair_gap", n, 0);
            next();
            smp();
            chk("fair_start", mem_start, 1);
            chk("fair_addr", mem_addr, 24'h010000 * (k + 1));
            next();
            mem_done  = 1'b1;
            mem_rdata = 32'hA0 + t;
            next();
            mem_done  = 1'b0;
            mem_rdata = '0;
            smp();
            chk("fair_done", rsp_done, 64'(1 << k));
            chk("fair_data", rsp_rdata, 32'hA0 + t);
            next();
        end
        req = '0;

        // write from requester 2
        req_addr[2*AW +: AW]  = 24'h00ABCD;
        req_wdata[2*DW +: DW] = 32'h12345678;
        req_size[2*3 +: 3]    = 3'b001;
        req_rd_wr[2]          = 1'b0;
        req                   = 3'b100;
        smp();
        chk("wr_gnt", gnt, 3'b100);
        next();
        req = '0;
        smp();
        chk("wr_start", mem_start, 1);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        chk("wr_dir", mem_rd_wr, 0);
        chk("wr_size", mem_size, 3'b001);
        next();
        mem_done  = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        smp();
        chk("wr_hold", {mem_addr, mem_wdata}, {24'h00ABCD, 32'h12345678});
        next();
        mem_done  = 1'b0;
        mem_rdata = '0;
        smp();
        chk("wr_done", rsp_done, 3'b100);
        chk("wr_rdata", rsp_rdata, 32'hA5);
        next();

        // reset in WAIT after moving ptr off zero
        req_rd_wr = 3'b111;
        txn_rd(0, 32'h11);
        req = 3'b100;
        smp();
        chk("rw_gnt", gnt, 3'b100);
        next();
        req = '0;
        next();
        next();
        rst = 1'b1;
        smp();
        chk("rw_rst_done", rsp_done, 0);
        next();
        rst = 1'b0;
        req = 3'b111;
        smp();
        chk("rw_busy", busy, 0);
        chk("rw_ptr0", gnt, 3'b001);
        chk("rw_nodone", rsp_done, 0);
        chk("rw_addr", mem_addr, 0);
        chk("rw_rdata", rsp_rdata, 0);
        next();
        req = '0;
        do_reset();

`ifdef PSRAM_ARB_TIMEOUT_EN
        // watchdog timeout with TIMEOUT_CYC = 16
        req = 3'b011;
        smp();
        chk("to_gnt", gnt, 3'b001);
        next();
        smp();
        chk("to_start", mem_start, 1);
        next();
        n = 0;
        smp();
        while (rsp_err == '0 && n < 40) begin
            smp();
            n++;
        end
        chk("to_lat", n, 16);
        chk("to_err", rsp_err, 3'b001);
        chk("to_nodone", rsp_done, 0);
        next();
        smp();
        chk("to_next", gnt, 3'b010);
        next();
        req = '0;
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 24, PSRAM byte address width.
REQ-003 Parameter DATA_W, default 32, transfer data width.
REQ-004 Parameter TIMEOUT_CYC, default 1024, watchdog limit (used only with PSRAM_ARB_TIMEOUT_EN).
REQ-005 Clock and reset: clk, rst; rst is synchronous and active-high, and the block is clocked on the rising edge of clk.
REQ-006 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_rd_wr  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W].
- req_size  in  NUM_REQ*3  packed byte-size codes.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot grant pulse.
- rsp_done  out  NUM_REQ  one-hot completion pulse.
- rsp_err  out  NUM_REQ  one-hot timeout-error pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_done.
- mem_start  out  1  controller start pulse.
- mem_rd_wr  out  1  controller direction.
- mem_addr  out  ADDR_W  controller address.
- mem_size  out  3  controller size code.
- mem_wdata  out  DATA_W  controller write data.
- mem_rdata  in  DATA_W  controller read data.
- mem_done  in  1  controller completion pulse.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-008 In IDLE with any req bit high, the arbiter SHALL select one requester round-robin, searching upward from pointer ptr with wrap from NUM_REQ-1 to 0.
REQ-009 In that same cycle it SHALL latch the selected requester's rd_wr, addr, size and wdata, pulse gnt[k] for one cycle, and go to ISSUE.
REQ-010 In ISSUE, mem_start SHALL be high for exactly one cycle with the latched fields on the mem_* outputs, and the FSM SHALL then go to WAIT.
REQ-011 The mem_* fields SHALL hold stable from ISSUE until the FSM returns to IDLE.
REQ-012 In WAIT, on mem_done the arbiter SHALL capture mem_rdata into rsp_rdata and go to RESP.
REQ-013 In RESP, rsp_done[k] SHALL pulse for one cycle, ptr SHALL become (k+1) mod NUM_REQ, and the FSM SHALL return to IDLE.
REQ-014 Minimum latency from a req sample in IDLE is: gnt in the same cycle, mem_start at +1, rsp_done one cycle after mem_done.
REQ-015 The rsp_rdata value SHALL hold until the next capture; for writes it SHALL be unchanged.
REQ-016 The req inputs SHALL be ignored outside IDLE; a requester may drop req after gnt.
REQ-017 A mem_done seen outside WAIT SHALL be ignored.
REQ-018 With a single persistent requester, that requester SHALL be served back-to-back with 1 idle cycle between transactions.
REQ-019 With all requesters continuously active, each SHALL be granted once per NUM_REQ transactions.
REQ-020 The gnt, rsp_done and rsp_err outputs SHALL be one-hot or zero at all times.

Reset
REQ-021 On rst the arbiter SHALL enter IDLE, set ptr=0, and clear gnt, rsp_done, rsp_err, mem_start, busy, mem_addr, mem_wdata, rsp_rdata and mem_rd_wr.
REQ-022 On rst, mem_size SHALL be set to 3'b010.
REQ-023 A reset asserted mid-transaction SHALL abandon the transaction with no rsp_done pulse, and the first cycle after reset SHALL be a normal IDLE.

Configuration
REQ-024 Macro PSRAM_ARB_TIMEOUT_EN: when defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-025 With PSRAM_ARB_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYC-1 without mem_done, the arbiter SHALL pulse rsp_err[k] (not rsp_done), advance ptr, and return to IDLE.
REQ-026 When PSRAM_ARB_TIMEOUT_EN is undefined, no counter SHALL exist, rsp_err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-027 Package psram_pkg SHALL hold the FSM state encoding, the size codes (SIZE_1B=000, SIZE_2B=001, SIZE_4B=010) and the default ADDR_W/DATA_W constants.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_select, with inputs req and ptr and outputs a one-hot grant and its index.

Verification
REQ-029 Single read: req=001, addr0=0x000100, rd_wr=1; mem_done with mem_rdata=0xDEADBEEF 5 cycles after mem_start -> gnt=001, mem_addr=0x000100, then rsp_done=001 with rsp_rdata=0xDEADBEEF.
REQ-030 Fairness: req=111 held for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-031 Write: requester 2 with addr=0x00ABCD, wdata=0x12345678, rd_wr=0 -> mem_wdata=0x12345678, mem_rd_wr=0, rsp_rdata unchanged.
REQ-032 Reset in WAIT: rst applied 2 cycles after mem_start -> no rsp_done, busy=0 and ptr=0 on the next cycle.
REQ-033 Timeout, with PSRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: mem_done never arrives -> rsp_err[k] pulses 16 cycles after WAIT entry, then the next requester is granted.
REQ-034 Stray mem_done while in IDLE -> no output change.
